ir_decode_stage: RTL

IR_DECODE_STAGE -- requirements
Module: ir_decode_stage

---
 rtl/ir_decode_stage_pkg.sv | 68 ++++++
 rtl/ir_decode_stage_opcode_decoder.sv | 54 +++++
 rtl/ir_decode_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ir_decode_stage_pkg.sv
// Shared constants for the IR/decode stage: opcode fields, one-hot bit map,
// flag bit positions and run-control state encoding.
package ir_decode_stage_pkg;

  localparam int unsigned IR_W     = 16;
  localparam int unsigned ONEHOT_W = 23;
  localparam int unsigned OPC_W    = 27;
  localparam int unsigned IMM_W    = 8;
  localparam int unsigned FLAG_W   = 4;

  // 4-bit major opcodes (IR[15:12])
  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_INPUT  = 4'h1;
  localparam logic [3:0] OP_MOVE   = 4'h2;
  localparam logic [3:0] OP_LOADI  = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SUBI   = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_LOADF  = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_STOREF = 4'hB;
  localparam logic [3:0] OP_SHIFT  = 4'hC;
  localparam logic [3:0] OP_CMP    = 4'hD;
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [3:0] OP_BRANCH = 4'hF;

  // Bit positions inside the one-hot instruction field
  localparam int unsigned BIT_NOOP    = 0;
  localparam int unsigned BIT_INPUTC  = 1;
  localparam int unsigned BIT_INPUTCF = 2;
  localparam int unsigned BIT_INPUTD  = 3;
  localparam int unsigned BIT_INPUTDF = 4;
  localparam int unsigned BIT_MOVE    = 5;
  localparam int unsigned BIT_LOADI   = 6;
  localparam int unsigned BIT_ADD     = 7;
  localparam int unsigned BIT_ADDI    = 8;
  localparam int unsigned BIT_SUB     = 9;
  localparam int unsigned BIT_SUBI    = 10;
  localparam int unsigned BIT_LOAD    = 11;
  localparam int unsigned BIT_LOADF   = 12;
  localparam int unsigned BIT_STORE   = 13;
  localparam int unsigned BIT_STOREF  = 14;
  localparam int unsigned BIT_SHIFTL  = 15;
  localparam int unsigned BIT_SHIFTR  = 16;
  localparam int unsigned BIT_CMP     = 17;
  localparam int unsigned BIT_JUMP    = 18;
  localparam int unsigned BIT_BRE     = 19;
  localparam int unsigned BIT_BRNE    = 20;
  localparam int unsigned BIT_BRG     = 21;
  localparam int unsigned BIT_BRGE    = 22;

  // Flag bit positions in alu_flags / flags_reg
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_C = 3;

  localparam logic [OPC_W-1:0] OPC_NOOP = OPC_W'(1);

  typedef enum logic [1:0] {
    RUN_HALT = 2'd0,
    RUN_CONT = 2'd1,
    RUN_STEP = 2'd2
  } run_state_t;

endpackage

// File: rtl/ir_decode_stage_opcode_decoder.sv
// Combinational IR -> {RX, RY, one-hot instruction} decoder.
module opcode_decoder
  import ir_decode_stage_pkg::*;
(
  input  logic [IR_W-1:0]  i_ir,
  output logic [OPC_W-1:0] o_opcode_c
);

  logic [ONEHOT_W-1:0] w_onehot;

  // Exactly one bit is set for every IR value; unused subcode bits are ignored.
  always_comb begin
    w_onehot = '0;
    case (i_ir[15:12])
      OP_NOOP:   w_onehot[BIT_NOOP]   = 1'b1;
      OP_INPUT: begin
        case (i_ir[9:8])
          2'b00:   w_onehot[BIT_INPUTC]  = 1'b1;
          2'b01:   w_onehot[BIT_INPUTCF] = 1'b1;
          2'b10:   w_onehot[BIT_INPUTD]  = 1'b1;
          default: w_onehot[BIT_INPUTDF] = 1'b1;
        endcase
      end
      OP_MOVE:   w_onehot[BIT_MOVE]   = 1'b1;
      OP_LOADI:  w_onehot[BIT_LOADI]  = 1'b1;
      OP_ADD:    w_onehot[BIT_ADD]    = 1'b1;
      OP_ADDI:   w_onehot[BIT_ADDI]   = 1'b1;
      OP_SUB:    w_onehot[BIT_SUB]    = 1'b1;
      OP_SUBI:   w_onehot[BIT_SUBI]   = 1'b1;
      OP_LOAD:   w_onehot[BIT_LOAD]   = 1'b1;
      OP_LOADF:  w_onehot[BIT_LOADF]  = 1'b1;
      OP_STORE:  w_onehot[BIT_STORE]  = 1'b1;
      OP_STOREF: w_onehot[BIT_STOREF] = 1'b1;
      OP_SHIFT: begin
        if (i_ir[8]) w_onehot[BIT_SHIFTR] = 1'b1;
        else         w_onehot[BIT_SHIFTL] = 1'b1;
      end
      OP_CMP:    w_onehot[BIT_CMP]    = 1'b1;
      OP_JUMP:   w_onehot[BIT_JUMP]   = 1'b1;
      default: begin
        // OP_BRANCH: condition selected by subcode
        case (i_ir[9:8])
          2'b00:   w_onehot[BIT_BRE]  = 1'b1;
          2'b01:   w_onehot[BIT_BRNE] = 1'b1;
          2'b10:   w_onehot[BIT_BRG]  = 1'b1;
          default: w_onehot[BIT_BRGE] = 1'b1;
        endcase
      end
    endcase
  end

  assign o_opcode_c = {i_ir[11:10], i_ir[9:8], w_onehot};

endmodule

// File: rtl/ir_decode_stage.sv
// Instruction register, registered decode, flags register and run/step control.
module ir_decode_stage
  import ir_decode_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [IR_W-1:0]   instr_in,
  input  logic              ir_load,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              flags_load,
  input  logic              run_mode,
  input  logic              step,
  input  logic              fsm_in_if,
  output logic [OPC_W-1:0]  opcode_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic [FLAG_W-1:0] flags_reg,
  output logic              run,
  output logic              instr_valid
);

  logic [IR_W-1:0]   r_ir;
  logic [OPC_W-1:0]  r_opcode;
  logic [IMM_W-1:0]  r_imm;
  logic [FLAG_W-1:0] r_flags;
  logic              r_valid;
  run_state_t        r_state;
  logic              r_run;
  logic              r_step_q;
  logic              r_step_loaded;

  logic [IR_W-1:0]   w_ir_next;
  logic              w_valid_next;
  logic [OPC_W-1:0]  w_dec;
  logic              w_step_rise;

  // Decode the value the IR will hold after this edge so opcode_out trails ir_load by one cycle.
  assign w_ir_next    = ir_load ? instr_in : r_ir;
  assign w_valid_next = r_valid | ir_load;
  assign w_step_rise  = step & ~r_step_q;

  opcode_decoder u_opcode_decoder (
    .i_ir       (w_ir_next),
    .o_opcode_c (w_dec)
  );

  // Instruction register, decoded opcode/immediate and valid flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ir     <= '0;
      r_opcode <= OPC_NOOP;
      r_imm    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_ir     <= w_ir_next;
      r_valid  <= w_valid_next;
      r_opcode <= w_valid_next ? w_dec : OPC_NOOP;
      r_imm    <= w_valid_next ? w_ir_next[IMM_W-1:0] : '0;
    end
  end

  // Flags register, independent of the IR load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (flags_load) begin
      r_flags <= alu_flags;
    end
  end

  // Run control: continuous run, or single instruction per step rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= RUN_HALT;
      r_run         <= 1'b0;
      r_step_q      <= 1'b0;
      r_step_loaded <= 1'b0;
    end else begin
      r_step_q <= step;
      case (r_state)
        RUN_HALT: begin
          if (run_mode) begin
            r_state <= RUN_CONT;
            r_run   <= 1'b1;
          end else if (w_step_rise) begin
            r_state       <= RUN_STEP;
            r_run         <= 1'b1;
            r_step_loaded <= 1'b0;
          end
        end
        RUN_CONT: begin
          // Stop only at an instruction boundary.
          if (!run_mode && fsm_in_if) begin
            r_state <= RUN_HALT;
            r_run   <= 1'b0;
          end
        end
        RUN_STEP: begin
          // Halt at the first fetch after this step's instruction was loaded.
          if (r_step_loaded && fsm_in_if) begin
            r_state       <= RUN_HALT;
            r_run         <= 1'b0;
            r_step_loaded <= 1'b0;
          end else if (ir_load) begin
            r_step_loaded <= 1'b1;
          end
        end
        default: begin
          r_state <= RUN_HALT;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  assign opcode_out  = r_opcode;
  assign imm_out     = r_imm;
  assign flags_reg   = r_flags;
  assign run         = r_run;
  assign instr_valid = r_valid;

endmodule
